risc_pipe_core: RTL and testbench
=================================

RISC_PIPE_CORE -- requirements
Module: risc_pipe_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/register width (16..64).
REQ-002 SHALL have parameter IMEM_AW, default 10, meaning instruction word-address width.
REQ-003 SHALL have parameter DMEM_AW, default 10, meaning data word-address width.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all flops rise-edge; no second clock phase.
REQ-006 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-007 SHALL have port imem_addr  out  IMEM_AW  meaning fetch address.
REQ-008 SHALL have port imem_rdata  in  32  meaning instruction, combinational from imem_addr.
REQ-009 SHALL have port dmem_addr  out  DMEM_AW  meaning load/store word address.
REQ-010 SHALL have port dmem_wdata  out  XLEN  meaning store data.
REQ-011 SHALL have port dmem_we  out  1  meaning store strobe, one cycle per SW.
REQ-012 SHALL have port dmem_rdata  in  XLEN  meaning load data, combinational from dmem_addr.
REQ-013 SHALL have port dbg_raddr  in  5  meaning debug register select.
REQ-014 SHALL have port dbg_rdata  out  XLEN  meaning combinational register-file read.
REQ-015 SHALL have port halted  out  1  meaning sticky halt flag.
REQ-016 SHALL have port retire_cnt  out  32  meaning count of instructions written back, wraps.

Function
REQ-017 SHALL implement five stages IF/ID/EX/MEM/WB, one clock per stage; first instruction retires on the 5th rising edge after rst falls.
REQ-018 SHALL decode opcode [31:26]: ADD 01,SUB 02,AND 03,OR 04,XOR 05,LW 06,SW 07,BNE 08,ADDI 09,SUBI 0A,ANDI 0B,ORI 0C,SLI 0D,SRI 0E,HLT 3F; 00 and all others = NOP (no side effect, not counted).
REQ-019 SHALL use rs=[25:21], rt=[20:16], rd=[15:11]; RR writes rd, RI/LW write rt; imm [15:0] sign-extended to XLEN.
REQ-020 SHALL take SLI/SRI shift amount from imm[$clog2(XLEN)-1:0], logical shifts only.
REQ-021 SHALL hold R0 at zero; writes to R0 discarded.
REQ-022 SHALL bypass the register file internally: WB write visible to an ID read in the same cycle.
REQ-023 SHALL resolve BNE in EX: taken when rs!=rt; next fetch from imm[IMEM_AW-1:0]; the two younger instructions in IF/ID and ID/EX flushed to NOP.
REQ-024 SHALL stall IF and ID one cycle, inserting a bubble into EX, when an ID instruction reads the rt of a LW currently in EX.
REQ-025 SHALL drive dmem_we=1 only while a non-flushed SW is in MEM; dmem_addr = (rs+imm)[DMEM_AW-1:0].
REQ-026 SHALL, on HLT decode, stop advancing pc and inject NOPs; set halted when HLT reaches WB; older instructions complete normally.
REQ-027 SHALL increment retire_cnt once per non-NOP, non-flushed instruction reaching WB, HLT included; wraps at 2^32.
REQ-028 SHALL give flush priority over stall when both occur in one cycle.
REQ-029 SHALL wrap pc at 2^IMEM_AW.

Reset
REQ-030 SHALL on rst: pc=RESET_PC, all pipeline registers NOP, dmem_we=0, halted=0, retire_cnt=0, registers R1..R31=0.
REQ-031 SHALL abort in-flight instructions on reset mid-operation, with no store issued after rst rises.

Configuration
REQ-032 SHALL with FORWARDING_EN defined forward EX/MEM and MEM/WB results to EX operands, youngest first; only REQ-024 stalls.
REQ-033 SHALL without FORWARDING_EN stall in ID while EX or MEM holds a writer of rs/rt, up to 2 cycles; results remain identical, cycle counts larger.

Structure
REQ-034 SHALL place opcodes, instruction-type enum and NOP encoding in package risc_pipe_pkg.
REQ-035 SHALL implement the register file as sub-module risc_pipe_regfile (2 read, 1 write, bypass, debug read).

Verification
REQ-036 SHALL test ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; HLT -> R3=12, retire_cnt=4, halted=1.
REQ-037 SHALL test back-to-back dependency ADDI R1,R0,1; ADD R1,R1,R1 x3 -> R1=8; 0 stalls with FORWARDING_EN, 2 per ADD without.
REQ-038 SHALL test SW R1(=0x2A) to addr 10, then LW R4 from 10, then ADD R5,R4,R4 -> dmem_we one pulse, R5=0x54, exactly one load-use stall.
REQ-039 SHALL test BNE R1,R2 taken to 20 with ADDI R6 in the two following slots -> R6 unchanged, next retire from 20; not-taken -> falls through.
REQ-040 SHALL test rst asserted while SW in EX -> dmem_we never 1, all outputs at reset values.
REQ-041 SHALL test SLI R7,R1(=1),31 with XLEN=32 -> R7=0x80000000; repeat XLEN=16 with amount 15 -> 0x8000.

Source files
------------

// File: rtl/risc_pipe_pkg.sv
// rtl/risc_pipe_pkg.sv - opcodes, instruction classes and NOP encoding for the five-stage core
package risc_pipe_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h06;
  localparam logic [5:0] OP_SW   = 6'h07;
  localparam logic [5:0] OP_BNE  = 6'h08;
  localparam logic [5:0] OP_ADDI = 6'h09;
  localparam logic [5:0] OP_SUBI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0B;
  localparam logic [5:0] OP_ORI  = 6'h0C;
  localparam logic [5:0] OP_SLI  = 6'h0D;
  localparam logic [5:0] OP_SRI  = 6'h0E;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [2:0] {
    IT_NOP, IT_RR, IT_RI, IT_LW, IT_SW, IT_BNE, IT_HLT
  } itype_e;

  function automatic itype_e op_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:                 op_type = IT_RR;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLI, OP_SRI:     op_type = IT_RI;
      OP_LW:                                                 op_type = IT_LW;
      OP_SW:                                                 op_type = IT_SW;
      OP_BNE:                                                op_type = IT_BNE;
      OP_HLT:                                                op_type = IT_HLT;
      default:                                               op_type = IT_NOP;
    endcase
  endfunction

endpackage

// File: rtl/risc_pipe_regfile.sv
// rtl/risc_pipe_regfile.sv - 32-entry register file, 2 read / 1 write, write-through reads, debug port
module risc_pipe_regfile
  import risc_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  // R0 is never written, so it stays at its reset value of zero
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reading the next-state array gives the same-cycle write bypass
  assign rd1       = regs_d[ra1];
  assign rd2       = regs_d[ra2];
  assign dbg_rdata = regs_q[dbg_raddr];

endmodule

// File: rtl/risc_pipe_core.sv
// rtl/risc_pipe_core.sv - five-stage in-order core (IF/ID/EX/MEM/WB) with branch flush and hazard stalls
// Define FORWARDING_EN for EX-stage operand forwarding; otherwise ID stalls on every RAW hazard.
module risc_pipe_core
  import risc_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IMEM_AW  = 10,
  parameter int DMEM_AW  = 10,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               dmem_we,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata,
  output logic               halted,
  output logic [31:0]        retire_cnt
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [IMEM_AW-1:0] PC_RST = IMEM_AW'(RESET_PC);

  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        ifid_q, ifid_d;
  logic               stop_q, stop_d;
  logic [5:0]         idex_op_q, idex_op_d, exmem_op_q, exmem_op_d, memwb_op_q, memwb_op_d;
  logic [4:0]         idex_wr_q, idex_wr_d, exmem_wr_q, exmem_wr_d, memwb_wr_q, memwb_wr_d;
  logic [XLEN-1:0]    idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;
  logic [XLEN-1:0]    exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d, memwb_val_q, memwb_val_d;
  logic               halted_q, halted_d;
  logic [31:0]        retire_q, retire_d;

  function automatic logic src_hit(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rs, input logic use_rt);
    src_hit = (wr != 5'd0) && ((use_rs && (wr == rs)) || (use_rt && (wr == rt)));
  endfunction

  itype_e id_t, ex_t, mem_t, wb_t;
  logic [4:0] id_rs, id_rt, id_wr;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic id_use_rs, id_use_rt, stall;

  assign id_t      = op_type(ifid_q[31:26]);
  assign id_rs     = ifid_q[25:21];
  assign id_rt     = ifid_q[20:16];
  assign id_imm    = XLEN'($signed(ifid_q[15:0]));
  assign id_use_rs = id_t inside {IT_RR, IT_RI, IT_LW, IT_SW, IT_BNE};
  assign id_use_rt = id_t inside {IT_RR, IT_SW, IT_BNE};
  assign id_wr     = (id_t == IT_RR) ? ifid_q[15:11] :
                     (id_t == IT_RI || id_t == IT_LW) ? id_rt : 5'd0;
  assign ex_t      = op_type(idex_op_q);
  assign mem_t     = op_type(exmem_op_q);
  assign wb_t      = op_type(memwb_op_q);

  risc_pipe_regfile #(.XLEN(XLEN)) u_regfile (
    .clk(clk), .rst(rst), .ra1(id_rs), .ra2(id_rt), .rd1(id_a), .rd2(id_b),
    .we(memwb_wr_q != 5'd0), .wa(memwb_wr_q), .wd(memwb_val_q),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  logic [XLEN-1:0] mem_val, fa, fb, ex_opb, ex_res;
  logic            br_taken;

  assign mem_val = (mem_t == IT_LW) ? dmem_rdata : exmem_res_q;

`ifdef FORWARDING_EN
  logic [4:0] idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d;

  assign idex_rs_d = id_rs;
  assign idex_rt_d = id_rt;
  assign stall     = (ex_t == IT_LW) && src_hit(idex_wr_q, id_rs, id_rt, id_use_rs, id_use_rt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_rs_q <= 5'd0;
      idex_rt_q <= 5'd0;
    end else begin
      idex_rs_q <= idex_rs_d;
      idex_rt_q <= idex_rt_d;
    end
  end

  // EX/MEM is checked last so the youngest producer wins
  always_comb begin
    fa = idex_a_q;
    fb = idex_b_q;
    if (memwb_wr_q != 5'd0 && memwb_wr_q == idex_rs_q) fa = memwb_val_q;
    if (memwb_wr_q != 5'd0 && memwb_wr_q == idex_rt_q) fb = memwb_val_q;
    if (exmem_wr_q != 5'd0 && exmem_wr_q == idex_rs_q) fa = mem_val;
    if (exmem_wr_q != 5'd0 && exmem_wr_q == idex_rt_q) fb = mem_val;
  end
`else
  assign stall = src_hit(idex_wr_q, id_rs, id_rt, id_use_rs, id_use_rt) ||
                 src_hit(exmem_wr_q, id_rs, id_rt, id_use_rs, id_use_rt);
  assign fa    = idex_a_q;
  assign fb    = idex_b_q;
`endif

  assign ex_opb   = (ex_t == IT_RR || ex_t == IT_BNE) ? fb : idex_imm_q;
  assign br_taken = (ex_t == IT_BNE) && (fa != fb);

  always_comb begin
    ex_res = '0;
    case (idex_op_q)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_res = fa + ex_opb;
      OP_SUB, OP_SUBI:               ex_res = fa - ex_opb;
      OP_AND, OP_ANDI:               ex_res = fa & ex_opb;
      OP_OR,  OP_ORI:                ex_res = fa | ex_opb;
      OP_XOR:                        ex_res = fa ^ ex_opb;
      OP_SLI:                        ex_res = fa << ex_opb[SHW-1:0];
      OP_SRI:                        ex_res = fa >> ex_opb[SHW-1:0];
      default:                       ex_res = '0;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    stop_d     = stop_q;
    idex_op_d  = (id_t == IT_NOP) ? OP_NOP : ifid_q[31:26];
    idex_wr_d  = id_wr;
    idex_a_d   = id_a;
    idex_b_d   = id_b;
    idex_imm_d = id_imm;
    if (br_taken) begin
      pc_d      = idex_imm_q[IMEM_AW-1:0];
      ifid_d    = NOP_INSN;
      idex_op_d = OP_NOP;
      idex_wr_d = 5'd0;
    end else if (stall) begin
      idex_op_d = OP_NOP;
      idex_wr_d = 5'd0;
    end else if (id_t == IT_HLT || stop_q) begin
      // Fetch freezes for good once HLT leaves ID
      ifid_d = NOP_INSN;
      stop_d = 1'b1;
    end else begin
      pc_d   = pc_q + 1'b1;
      ifid_d = imem_rdata;
    end
    exmem_op_d  = idex_op_q;
    exmem_wr_d  = idex_wr_q;
    exmem_res_d = ex_res;
    exmem_sd_d  = fb;
    memwb_op_d  = exmem_op_q;
    memwb_wr_d  = exmem_wr_q;
    memwb_val_d = mem_val;
    halted_d    = halted_q | (wb_t == IT_HLT);
    retire_d    = retire_q + 32'(wb_t != IT_NOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= PC_RST;
      ifid_q      <= NOP_INSN;
      stop_q      <= 1'b0;
      idex_op_q   <= OP_NOP;
      idex_wr_q   <= 5'd0;
      idex_a_q    <= '0;
      idex_b_q    <= '0;
      idex_imm_q  <= '0;
      exmem_op_q  <= OP_NOP;
      exmem_wr_q  <= 5'd0;
      exmem_res_q <= '0;
      exmem_sd_q  <= '0;
      memwb_op_q  <= OP_NOP;
      memwb_wr_q  <= 5'd0;
      memwb_val_q <= '0;
      halted_q    <= 1'b0;
      retire_q    <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      stop_q      <= stop_d;
      idex_op_q   <= idex_op_d;
      idex_wr_q   <= idex_wr_d;
      idex_a_q    <= idex_a_d;
      idex_b_q    <= idex_b_d;
      idex_imm_q  <= idex_imm_d;
      exmem_op_q  <= exmem_op_d;
      exmem_wr_q  <= exmem_wr_d;
      exmem_res_q <= exmem_res_d;
      exmem_sd_q  <= exmem_sd_d;
      memwb_op_q  <= memwb_op_d;
      memwb_wr_q  <= memwb_wr_d;
      memwb_val_q <= memwb_val_d;
      halted_q    <= halted_d;
      retire_q    <= retire_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = exmem_res_q[DMEM_AW-1:0];
  assign dmem_wdata = exmem_sd_q;
  assign dmem_we    = (mem_t == IT_SW);
  assign halted     = halted_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_risc_pipe_core.sv
// tb/tb_risc_pipe_core.sv - directed program vectors for risc_pipe_core (32-bit and 16-bit instances)
module tb_risc_pipe_core;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [5:0] ADD = 6'h01, LW = 6'h06, SW = 6'h07, BNE = 6'h08;
  localparam logic [5:0] ADDI = 6'h09, SLI = 6'h0D, SRI = 6'h0E;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata, retire_cnt;
  logic        dmem_we, halted;
  logic [4:0]  dbg_raddr;
  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  int          we_cnt = 0;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  risc_pipe_core dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .halted(halted), .retire_cnt(retire_cnt)
  );

  logic [9:0]  s_imem_addr, s_dmem_addr;
  logic [31:0] s_imem_rdata, s_retire_cnt;
  logic [15:0] s_dmem_wdata, s_dmem_rdata, s_dbg_rdata;
  logic        s_dmem_we, s_halted;
  logic [4:0]  s_dbg_raddr;
  logic [31:0] imem16 [1024];
  logic [15:0] dmem16 [1024];

  assign s_imem_rdata = imem16[s_imem_addr];
  assign s_dmem_rdata = dmem16[s_dmem_addr];
  always @(posedge clk) if (s_dmem_we) dmem16[s_dmem_addr] <= s_dmem_wdata;

  risc_pipe_core #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
    .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata), .dmem_we(s_dmem_we), .dmem_rdata(s_dmem_rdata),
    .dbg_raddr(s_dbg_raddr), .dbg_rdata(s_dbg_rdata), .halted(s_halted), .retire_cnt(s_retire_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic load_prog(input int id);
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
    case (id)
      0: begin
        imem[0] = ri(ADDI, 1, 0, 16'd5); imem[1] = ri(ADDI, 2, 0, 16'd7);
        imem[2] = rr(ADD, 3, 1, 2);      imem[3] = HLT;
      end
      1: begin
        imem[0] = ri(ADDI, 1, 0, 16'd1);
        for (int i = 1; i <= 3; i++) imem[i] = rr(ADD, 1, 1, 1);
        imem[4] = HLT;
      end
      2: begin
        imem[0] = ri(ADDI, 1, 0, 16'h2A); imem[1] = ri(SW, 1, 0, 16'd10);
        imem[2] = ri(LW, 4, 0, 16'd10);   imem[3] = rr(ADD, 5, 4, 4); imem[4] = HLT;
      end
      3: begin
        imem[0] = ri(ADDI, 1, 0, 16'd1);    imem[1] = ri(BNE, 2, 1, 16'd20);
        imem[2] = ri(ADDI, 6, 0, 16'h66);   imem[3] = ri(ADDI, 6, 0, 16'h77);
        imem[20] = ri(ADDI, 8, 0, 16'd9);   imem[21] = HLT;
      end
      4: begin
        imem[0] = ri(ADDI, 1, 0, 16'd3);    imem[1] = ri(ADDI, 2, 0, 16'd3);
        imem[2] = ri(BNE, 2, 1, 16'd20);    imem[3] = ri(ADDI, 6, 0, 16'h66); imem[4] = HLT;
        imem[20] = ri(ADDI, 6, 0, 16'h77);  imem[21] = HLT;
      end
      5: begin
        imem[0] = ri(ADDI, 1, 0, 16'd1);    imem[1] = 32'h40A5_FFFF;
        imem[2] = ri(SLI, 7, 1, 16'd31);    imem[3] = ri(SRI, 9, 7, 16'd4); imem[4] = HLT;
      end
      6: begin
        imem[0] = ri(ADDI, 0, 0, 16'd9);    imem[1] = rr(ADD, 10, 0, 0); imem[2] = HLT;
      end
      default: begin
        imem[0] = ri(ADDI, 1, 0, 16'h2A);   imem[1] = ri(SW, 1, 0, 16'd5); imem[2] = HLT;
      end
    endcase
  endtask

  task automatic run_prog(input int id, output int cycles);
    rst = 1'b1;
    load_prog(id);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (!halted && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  typedef struct {
    int          prog;
    int          retire;
    int          cyc;
    logic [4:0]  ra;
    logic [31:0] va;
    logic [4:0]  rb;
    logic [31:0] vb;
    int          we;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc, base, n;
    logic [31:0] v;

    vecs[0] = '{0, 4, FWD ? 8 : 10,  5'd3,  32'd12,        5'd1, 32'd5,         0};
    vecs[1] = '{1, 5, FWD ? 9 : 15,  5'd1,  32'd8,         5'd0, 32'd0,         0};
    vecs[2] = '{2, 5, FWD ? 10 : 13, 5'd5,  32'h54,        5'd4, 32'h2A,        1};
    vecs[3] = '{3, 4, FWD ? 10 : 12, 5'd6,  32'd0,         5'd8, 32'd9,         0};
    vecs[4] = '{4, 5, FWD ? 9 : 11,  5'd6,  32'h66,        5'd1, 32'd3,         0};
    vecs[5] = '{5, 4, FWD ? 9 : 12,  5'd7,  32'h8000_0000, 5'd9, 32'h0800_0000, 0};
    vecs[6] = '{6, 3, 7,             5'd10, 32'd0,         5'd0, 32'd0,         0};

    for (int i = 0; i < 1024; i++) imem16[i] = 32'd0;
    imem16[0] = ri(ADDI, 1, 0, 16'd1);
    imem16[1] = ri(SLI, 7, 1, 16'd15);
    imem16[2] = HLT;

    rst = 1'b1;
    dbg_raddr = 5'd0;
    s_dbg_raddr = 5'd7;
    load_prog(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_retire", retire_cnt, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_we", {31'd0, dmem_we}, 32'd0);
    chk("reset_pc", {22'd0, imem_addr}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      base = we_cnt;
      run_prog(vecs[i].prog, cyc);
      chk($sformatf("p%0d_halted", i), {31'd0, halted}, 32'd1);
      chk($sformatf("p%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("p%0d_retire", i), retire_cnt, 32'(vecs[i].retire));
      read_reg(vecs[i].ra, v);
      chk($sformatf("p%0d_r%0d", i, vecs[i].ra), v, vecs[i].va);
      read_reg(vecs[i].rb, v);
      chk($sformatf("p%0d_r%0d", i, vecs[i].rb), v, vecs[i].vb);
      chk($sformatf("p%0d_stores", i), 32'(we_cnt - base), 32'(vecs[i].we));
      if (vecs[i].prog == 2) chk("p2_dmem10", dmem[10], 32'h2A);
    end

    n = 0;
    while (!s_halted && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("x16_halted", {31'd0, s_halted}, 32'd1);
    chk("x16_retire", s_retire_cnt, 32'd3);
    chk("x16_r7", {16'd0, s_dbg_rdata}, 32'h0000_8000);

    rst = 1'b1;
    load_prog(7);
    dmem[5] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = we_cnt;
    repeat (FWD ? 3 : 5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_we_now", {31'd0, dmem_we}, 32'd0);
    chk("midrst_retire", retire_cnt, 32'd0);
    chk("midrst_pc", {22'd0, imem_addr}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_stores", 32'(we_cnt - base), 32'd0);
    chk("midrst_dmem5", dmem[5], 32'h1234_5678);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    read_reg(5'd1, v);
    chk("midrst_r1", v, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
